// File: rtl/rv32i_fetch_pkg.sv
// Shared types for the RV32I prefetching fetch stage: FIFO entry layout, fetch state and PC helpers.
// Imported by the fetch FIFO and the fetch-stage top.
package rv32i_fetch_pkg;

  localparam logic [31:0] NOOP_INSTRUCTION = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Synchronous prefetch FIFO with flush; push lands on the head one cycle later, pop frees immediately.
// Push is dropped when full unless a pop happens the same cycle; flush beats push.
module rv32i_fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         flush,
  input  logic                         push,
  input  T                             push_dat,
  input  logic                         pop,
  output T                             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/rv32i_prefetch_fetch_stage.sv
// RV32I fetch with up to MAX_OUTSTANDING in-order imem requests feeding a prefetch FIFO; rsp -> decode in 1 cycle.
// Requests are credit-limited by free FIFO slots, so decode backpressure simply stops issue; redirect flushes and drains.
module rv32i_prefetch_fetch_stage
  import rv32i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_en,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_imem_rsp_err,
  output logic        o_fetch_valid,
  input  logic        i_decode_ready,
  output logic [31:0] o_fetch_instr,
  output logic [31:0] o_fetch_pc,
  output logic        o_fetch_fault
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic [OW-1:0] outstanding_nxt;
  logic [OW-1:0] drop_cnt_nxt;
  logic [OW-1:0] live_outstanding;
  logic [31:0]   credit_used;
  logic          issue_ok;
  logic          credit_ok;
  logic          req_accept;
  logic          rsp_take;
  logic          rsp_drop;
  logic          rsp_keep;

  fetch_entry_t  fifo_push_dat;
  fetch_entry_t  fifo_head;
  logic          fifo_push;
  logic          fifo_pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;

  // Responses already condemned by a redirect never reach the FIFO, so they hold no credit.
  assign live_outstanding = outstanding - drop_cnt;
  assign credit_used      = 32'(fifo_count) + 32'(live_outstanding);
  assign issue_ok         = (outstanding < OW'(MAX_OUTSTANDING));
  assign credit_ok        = (credit_used < 32'(FIFO_DEPTH));

  assign o_imem_req_valid = ~i_rst & i_fetch_en & ~i_redirect_valid & issue_ok & credit_ok;
  assign o_imem_req_addr  = fetch_pc;
  assign req_accept       = o_imem_req_valid & i_imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign rsp_take = i_imem_rsp_valid & (outstanding != '0);
  assign rsp_drop = rsp_take & (state == ST_DRAIN);
  assign rsp_keep = rsp_take & ~rsp_drop & ~i_redirect_valid;

  always_comb begin
    outstanding_nxt = outstanding + OW'(req_accept) - OW'(rsp_take);
    drop_cnt_nxt    = drop_cnt - OW'(rsp_drop);
    if (i_redirect_valid) drop_cnt_nxt = outstanding_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_HOLD;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_cnt_nxt;
      if (drop_cnt_nxt != '0) begin
        state <= ST_DRAIN;
      end else if (i_fetch_en) begin
        state <= ST_RUN;
      end else begin
        state <= ST_HOLD;
      end
      if (i_redirect_valid) begin
        fetch_pc <= word_align(i_redirect_pc);
        rsp_pc   <= word_align(i_redirect_pc);
      end else begin
        if (req_accept) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_keep)   rsp_pc   <= rsp_pc + 32'd4;
      end
    end
  end

  assign fifo_push_dat = '{pc: rsp_pc, instr: i_imem_rsp_data, fault: i_imem_rsp_err};
  assign fifo_push     = rsp_keep;
  // Decode must flush on redirect, so its handshake that cycle is ignored.
  assign fifo_pop      = ~fifo_empty & i_decode_ready & ~i_redirect_valid;

  rv32i_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .flush    (i_redirect_valid),
    .push     (fifo_push),
    .push_dat (fifo_push_dat),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign o_fetch_valid = ~fifo_empty;
  assign o_fetch_instr = fifo_empty ? NOOP_INSTRUCTION : fifo_head.instr;
  assign o_fetch_pc    = fifo_empty ? 32'h0 : fifo_head.pc;
  assign o_fetch_fault = ~fifo_empty & fifo_head.fault;

  orphan_rsp_a: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_imem_rsp_valid && outstanding == '0));

  fifo_overflow_a: assert property (@(posedge i_clk) disable iff (i_rst)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule
